// File: rtl/arb_pkg.sv
// Shared types and helpers for the registered priority arbiter.
package arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_t;

  // Widest requester vector the index helper supports.
  localparam int unsigned MaxN = 64;

  function automatic int unsigned onehot_to_idx(input logic [MaxN-1:0] oh);
    int unsigned idx = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (oh[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational highest-set-bit picker: one-hot, binary index and any flag.
module prio_pick
  import arb_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] vec_i,
  output logic [N-1:0] onehot_o,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic [MaxN-1:0] oh_ext;

  always_comb begin
    onehot_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (vec_i[i]) begin
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
    oh_ext         = '0;
    oh_ext[N-1:0]  = onehot_o;
    idx_o          = W'(onehot_to_idx(oh_ext));
    any_o          = |vec_i;
  end

endmodule

// File: rtl/prio_arbiter_n.sv
// Registered N-requester priority arbiter with grant locking and hold-limit preemption.
// Optional round-robin search order is enabled by defining ROUND_ROBIN_EN.
module prio_arbiter_n
  import arb_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned MAX_HOLD = 16,
  localparam int unsigned W       = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_idx,
  output logic         grant_valid,
  output logic         preempt
);

  // Keeps the counter at least one bit wide when the timeout is disabled.
  localparam int unsigned HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  arb_state_t   state_q, state_d;
  logic [N-1:0] grant_q, grant_d;
  logic [W-1:0] grant_idx_q, grant_idx_d;
  logic         grant_valid_q, grant_valid_d;
  logic         preempt_q, preempt_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [N-1:0] mask_q, mask_d;

  logic [N-1:0] req_eff;
  logic [N-1:0] pick_in, pick_oh, win_oh;
  logic [W-1:0] pick_idx, win_idx;
  logic         pick_any;
  logic         timeout;

  assign req_eff = req & ~mask_q;
  assign timeout = (MAX_HOLD > 0) && (hold_q == HW'(MAX_HOLD - 1));

  prio_pick #(
    .N(N),
    .W(W)
  ) u_pick (
    .vec_i   (pick_in),
    .onehot_o(pick_oh),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

`ifdef ROUND_ROBIN_EN
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] src;

  // Rotate so index ptr-1 lands on the top (highest priority) position.
  always_comb begin
    pick_in = '0;
    win_oh  = '0;
    src     = '0;
    for (int unsigned j = 0; j < N; j++) begin
      src          = W'((j + 32'(ptr_q)) % N);
      pick_in[j]   = req_eff[src];
      win_oh[src]  = pick_oh[j];
    end
    win_idx = W'((32'(pick_idx) + 32'(ptr_q)) % N);
  end
`else
  assign pick_in = req_eff;
  assign win_oh  = pick_oh;
  assign win_idx = pick_idx;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    grant_idx_d   = grant_idx_q;
    grant_valid_d = grant_valid_q;
    preempt_d     = 1'b0;
    hold_d        = hold_q;
    mask_d        = mask_q;
`ifdef ROUND_ROBIN_EN
    ptr_d         = ptr_q;
`endif
    unique case (state_q)
      ARB_IDLE: begin
        // The mask covers exactly one arbitration edge.
        mask_d = '0;
        if (pick_any) begin
          state_d       = ARB_GRANT;
          grant_d       = win_oh;
          grant_idx_d   = win_idx;
          grant_valid_d = 1'b1;
          hold_d        = '0;
`ifdef ROUND_ROBIN_EN
          ptr_d         = win_idx;
`endif
        end
      end
      ARB_GRANT: begin
        if (!req[grant_idx_q] || timeout) begin
          state_d       = ARB_IDLE;
          grant_d       = '0;
          grant_idx_d   = '0;
          grant_valid_d = 1'b0;
          hold_d        = '0;
          // A simultaneous drop wins over the timeout: no preempt, no mask.
          if (req[grant_idx_q]) begin
            preempt_d = 1'b1;
            mask_d    = grant_q;
          end
        end else if (MAX_HOLD > 0) begin
          hold_d = hold_q + HW'(1);
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ARB_IDLE;
      grant_q       <= '0;
      grant_idx_q   <= '0;
      grant_valid_q <= 1'b0;
      preempt_q     <= 1'b0;
      hold_q        <= '0;
      mask_q        <= '0;
`ifdef ROUND_ROBIN_EN
      ptr_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      grant_idx_q   <= grant_idx_d;
      grant_valid_q <= grant_valid_d;
      preempt_q     <= preempt_d;
      hold_q        <= hold_d;
      mask_q        <= mask_d;
`ifdef ROUND_ROBIN_EN
      ptr_q         <= ptr_d;
`endif
    end
  end

  assign grant       = grant_q;
  assign grant_idx   = grant_idx_q;
  assign grant_valid = grant_valid_q;
  assign preempt     = preempt_q;

endmodule

// File: tb/tb_prio_arbiter_n.sv
// Directed self-checking bench for prio_arbiter_n with N = 4, MAX_HOLD = 4.
module tb_prio_arbiter_n;

  localparam int unsigned N       = 4;
  localparam int unsigned MaxHold = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;
  logic       preempt;

  int n_cmp = 0;
  int n_err = 0;

  prio_arbiter_n #(
    .N       (N),
    .MAX_HOLD(MaxHold)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid),
    .preempt    (preempt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Observed outputs packed as {grant, grant_idx, grant_valid, preempt}.
  wire [7:0] obs = {grant, grant_idx, grant_valid, preempt};

  function automatic logic [7:0] exp_obs(input logic [3:0] g, input logic [1:0] i,
                                         input logic p);
    return {g, i, |g, p};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst_n = 1'b1;
    req   = 4'b1111;
    #1 rst_n = 1'b0;
    #1;
    e = exp_obs(4'b0000, 2'd0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_async: got %b want %b", obs, e);
    end
    tick();
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_held: got %b want %b", obs, e);
    end
    rst_n = 1'b1;
    req   = 4'b0000;
    tick();
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL reset_idle: got %b want %b", obs, e);
    end
  endtask

  task automatic test_fixed_priority();
    logic [7:0] e;
    req = 4'b0110;
    tick();
    e = exp_obs(4'b0100, 2'd2, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL fp_first: got %b want %b", obs, e);
    end
    req = 4'b0010;
    tick();
    e = exp_obs(4'b0000, 2'd0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL fp_bubble: got %b want %b", obs, e);
    end
    tick();
    e = exp_obs(4'b0010, 2'd1, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL fp_second: got %b want %b", obs, e);
    end
  endtask

  task automatic test_lock();
    logic [7:0] e;
    req = 4'b1010;
    for (int c = 0; c < 2; c++) begin
      tick();
      e = exp_obs(4'b0010, 2'd1, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL lock_hold[%0d]: got %b want %b", c, obs, e);
      end
    end
    req = 4'b1000;
    tick();
    e = exp_obs(4'b0000, 2'd0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL lock_release: got %b want %b", obs, e);
    end
    tick();
    e = exp_obs(4'b1000, 2'd3, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL lock_next: got %b want %b", obs, e);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_timeout();
    logic [7:0] e;
    req = 4'b1001;
    for (int c = 0; c < 4; c++) begin
      tick();
      e = exp_obs(4'b1000, 2'd3, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL to_hold3[%0d]: got %b want %b", c, obs, e);
      end
    end
    tick();
    e = exp_obs(4'b0000, 2'd0, 1'b1);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL to_preempt3: got %b want %b", obs, e);
    end
    for (int c = 0; c < 4; c++) begin
      tick();
      e = exp_obs(4'b0001, 2'd0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL to_masked_hold0[%0d]: got %b want %b", c, obs, e);
      end
    end
    tick();
    e = exp_obs(4'b0000, 2'd0, 1'b1);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL to_preempt0: got %b want %b", obs, e);
    end
    tick();
    e = exp_obs(4'b1000, 2'd3, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL to_regrant3: got %b want %b", obs, e);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_simultaneous();
    logic [7:0] e;
    req = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      tick();
      e = exp_obs(4'b1000, 2'd3, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL sim_hold[%0d]: got %b want %b", c, obs, e);
      end
    end
    req = 4'b0000;
    tick();
    e = exp_obs(4'b0000, 2'd0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL sim_no_preempt: got %b want %b", obs, e);
    end
    req = 4'b1001;
    tick();
    e = exp_obs(4'b1000, 2'd3, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL sim_no_mask: got %b want %b", obs, e);
    end
  endtask

  task automatic test_reset_mid_grant();
    logic [7:0] e;
    #2 rst_n = 1'b0;
    #1;
    e = exp_obs(4'b0000, 2'd0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL rst_mid_async: got %b want %b", obs, e);
    end
    tick();
    rst_n = 1'b1;
    req   = 4'b0001;
    tick();
    e = exp_obs(4'b0001, 2'd0, 1'b0);
    n_cmp++;
    if (obs !== e) begin
      n_err++;
      $display("FAIL rst_mid_regrant: got %b want %b", obs, e);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] e;
    logic [1:0] seq [5];
`ifdef ROUND_ROBIN_EN
    seq = '{2'd3, 2'd2, 2'd1, 2'd0, 2'd3};
`else
    seq = '{2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
`endif
    for (int k = 0; k < 5; k++) begin
      req = 4'b1111;
      tick();
      e = exp_obs(4'b0001 << seq[k], seq[k], 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL b2b_grant[%0d]: got %b want %b", k, obs, e);
      end
      req = 4'b0000;
      tick();
      e = exp_obs(4'b0000, 2'd0, 1'b0);
      n_cmp++;
      if (obs !== e) begin
        n_err++;
        $display("FAIL b2b_bubble[%0d]: got %b want %b", k, obs, e);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    req   = 4'b0000;
    test_reset();
    test_fixed_priority();
    test_lock();
    test_timeout();
    test_simultaneous();
    test_reset_mid_grant();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/prio_arbiter_n.md
# prio_arbiter_n

Parametrised, registered N-requester priority arbiter with grant locking. It is the sequential successor to the 4:2 priority encoder: the highest-index active request wins, and both a one-hot grant and its binary index are driven. The grant is then held until the owner releases it or a hold-limit timeout preempts it. It sits between shared-resource requesters (bus masters, DMA channels) and the resource mux select.

## Interface
- N, default 8: number of requesters, ≥ 2.
- MAX_HOLD, default 16: maximum consecutive grant cycles per owner. 0 means unlimited (timeout logic removed).
- W (localparam): $clog2(N), the index width.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  N  request vector; bit i high means requester i wants the resource.
- grant  out  N  one-hot grant; all zero when idle.
- grant_idx  out  W  binary index of the current owner; 0 when idle.
- grant_valid  out  1  high while a grant is active; equals |grant.
- preempt  out  1  one-cycle pulse after a forced release due to timeout.

## Operation
- FSM has two states: ARB_IDLE and ARB_GRANT.
- **ARB_IDLE**
  - At a clock edge with |req_eff = 1, register the winner and go to ARB_GRANT.
  - Otherwise stay in ARB_IDLE.
- **Winner selection (fixed priority):** highest set index of req_eff, matching the 4:2 encoder priority order (bit N-1 highest).
- **req_eff:** req with the masked bit cleared. The masked bit is the index preempted in the immediately preceding grant. The mask is valid for one arbitration only and cleared otherwise.
- **ARB_GRANT**
  - Owner index is frozen. Other requests are ignored.
  - At an edge with req[owner] = 0, go to ARB_IDLE (voluntary release, preempt = 0).
  - At an edge with req[owner] = 1 and hold_cnt = MAX_HOLD-1 (MAX_HOLD > 0), go to ARB_IDLE (forced release). Assert preempt for the following cycle and mask the owner for the next arbitration.
- **hold_cnt**
  - Width is $clog2(MAX_HOLD+1).
  - Cleared on entry to ARB_GRANT and incremented each GRANT cycle.
  - Never wraps, because the exit fires first.
- **Simultaneous events:** if an owner drops req on the same edge the timeout fires, it is treated as a voluntary release (no preempt, no mask).
- **Masked sole request:** if the only active request is masked, there is no grant that edge. The mask then clears and the requester wins the next edge.

## Timing
- **Reset values:** state ARB_IDLE, grant = 0, grant_idx = 0, grant_valid = 0, preempt = 0, hold_cnt = 0, mask = 0, RR pointer = 0. All apply asynchronously on rst_n low, including mid-grant.
- **Grant latency:** req first sampled high at edge E in IDLE → grant visible after E (1 cycle).
- **Release:** req[owner] sampled low at edge E → grant = 0 after E. The earliest next grant is after E+1, so there is always exactly one idle bubble cycle between grants.
- **Grant duration:** a grant lasts at most MAX_HOLD cycles.
- **All outputs are registered.** No combinational path from req to any output.

## Configuration
- **ROUND_ROBIN_EN defined:** the search order after a grant to k is k-1, k-2, …, 0, N-1, …, k (pointer = last granted index, updated on every grant). With pointer = 0 after reset, the first arbitration equals fixed priority. The preempt mask still applies.
- **Not defined:** fixed priority only, and the pointer logic is absent.

## Structure
- **Package arb_pkg:** arb_state_t enum (ARB_IDLE, ARB_GRANT) and an onehot-to-index function.
- **Sub-module prio_pick (combinational):** input vector N, output one-hot and index of the highest set bit, plus an any flag.
  - Round-robin mode rotates the vector by the pointer before prio_pick and un-rotates the result afterwards.

## Test plan
All scenarios use N = 4, MAX_HOLD = 4.
1. **Fixed priority:** req = 4'b0110 from reset → after 1 edge, grant = 4'b0100, grant_idx = 2, grant_valid = 1. Then req = 4'b0010 → grant = 0 for 1 cycle, then grant = 4'b0010, grant_idx = 1.
2. **Lock:** owner 1 granted, then req = 4'b1010 → grant stays 4'b0010 until req[1] drops. Then 1 idle cycle, then grant = 4'b1000, grant_idx = 3.
3. **Timeout:** req = 4'b1001 held constant → grant_idx = 3 for exactly 4 cycles, then 1 idle cycle with preempt = 1, then grant_idx = 0 (bit 3 masked), then grant_idx = 3 again.
4. **Simultaneous:** req[3] drops on the 4th grant cycle → preempt stays 0 and no mask applies.
5. **Reset mid-grant:** rst_n low while grant = 4'b1000 → all outputs 0 immediately. After release, req = 4'b0001 → grant_idx = 0 one edge later.
6. **ROUND_ROBIN_EN, fairness:** req = 4'b1111 with voluntary drop-and-reraise after each grant → grant_idx sequence 3, 2, 1, 0, 3.
